ifetch_queue: RTL



---
 rtl/ifq_pkg.sv | 23 ++
 rtl/ifetch_queue_if.sv | 27 ++
 rtl/ifq_fifo.sv | 52 +++++
 rtl/ifetch_queue.sv | 117 +++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// The fetch FSM states and the buffered {pc, instr} entry live here.
package ifq_pkg;

  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    WAIT_SQ = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue.
// master = the fetch queue, slave = its environment (imem + decode).
interface ifetch_queue_if;
  import ifq_pkg::*;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc
  );

endinterface

// File: rtl/ifq_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries with flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ifq_entry_t    push_entry,
  output logic [CW-1:0] count,
  output logic          head_valid,
  output ifq_entry_t    head
);

  ifq_entry_t      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns fetch_pc, issues imem requests, buffers
// words for decode and squashes on redirect. Optional macro: IFQ_BYPASS_EN.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  ifetch_queue_if.master  ifq
);

  localparam int CW = $clog2(DEPTH + 1);

  ifq_state_e      state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic            req_q, req_n;

  logic            redirect;
  logic            req_done;
  logic            word_kept;
  logic            push;
  logic            pop;
  logic            fifo_valid;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  ifq_entry_t      head;
  ifq_entry_t      push_entry;

  assign redirect   = ifq.redirect_valid;
  // Any ack while a request is outstanding completes it, squashed or not.
  assign req_done   = ifq.imem_ack && (state != IDLE);
  assign word_kept  = ifq.imem_ack && (state == WAIT) && !redirect;
  assign pop        = fifo_valid && ifq.inst_ready && !redirect;
  assign push_entry = '{pc: fetch_pc, instr: ifq.imem_rdata};

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // An acked word reaches decode in the same cycle when nothing is queued
  // ahead of it; it only enters the FIFO if decode does not take it.
  assign bypass         = word_kept && !fifo_valid;
  assign push           = word_kept && !(bypass && ifq.inst_ready);
  assign ifq.inst_valid = fifo_valid || bypass;
  assign ifq.inst_data  = bypass ? ifq.imem_rdata : head.instr;
  assign ifq.inst_pc    = bypass ? fetch_pc       : head.pc;
`else
  assign push           = word_kept;
  assign ifq.inst_valid = fifo_valid;
  assign ifq.inst_data  = head.instr;
  assign ifq.inst_pc    = head.pc;
`endif

  assign count_next = redirect ? '0 : (count + CW'(push) - CW'(pop));

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_entry (push_entry),
    .count      (count),
    .head_valid (fifo_valid),
    .head       (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_q    <= req_n;
      addr_q   <= addr_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through it leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_n      = req_q;
    addr_n     = addr_q;

    if (redirect) begin
      fetch_pc_n = word_align(ifq.redirect_pc);
    end else if (word_kept) begin
      fetch_pc_n = fetch_pc + XLEN'(WORD_BYTES);
    end

    // The bus is free: issue at the next PC only if the returning word is
    // guaranteed a FIFO slot (count + outstanding never exceeds DEPTH).
    if (state == IDLE || req_done) begin
      addr_n = fetch_pc_n;
      if (count_next < CW'(DEPTH)) begin
        req_n   = 1'b1;
        state_n = WAIT;
      end else begin
        req_n   = 1'b0;
        state_n = IDLE;
      end
    end else if (redirect) begin
      state_n = WAIT_SQ;
    end
  end

  assign ifq.imem_req  = req_q;
  assign ifq.imem_addr = addr_q;

endmodule
